// File: rtl/stream_window_acc_pkg.sv
// Shared types and constants for the windowed stream accumulator.
// STREAM_WINDOW_ACC_SATURATE_EN selects clamping instead of wrap-around
// when the running sum overflows.
package stream_window_acc_pkg;

    // Control states of the accumulator.
    typedef enum logic [1:0] {
        SWA_IDLE   = 2'd0,
        SWA_DELAY  = 2'd1,
        SWA_ACC    = 2'd2,
        SWA_FINISH = 2'd3
    } swa_state_e;

    // Default sample/result width and its signed extremes.
    localparam int                    SWA_DATA_W = 32;
    localparam logic [SWA_DATA_W-1:0] SWA_SMAX   = {1'b0, {(SWA_DATA_W-1){1'b1}}};
    localparam logic [SWA_DATA_W-1:0] SWA_SMIN   = {1'b1, {(SWA_DATA_W-1){1'b0}}};

endpackage

// File: rtl/stream_window_acc_add_ovf.sv
// Combinational signed adder with overflow detection.
// With STREAM_WINDOW_ACC_SATURATE_EN defined the result clamps to the signed
// maximum or minimum on overflow; otherwise it wraps modulo 2^W.
module swa_add_ovf #(
    parameter int W = stream_window_acc_pkg::SWA_DATA_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] rawSum;

    // Overflow is only possible when both operands share a sign and the result flips it.
    always_comb begin
        rawSum = a_i + b_i;
        ovf_o  = (a_i[W-1] == b_i[W-1]) && (rawSum[W-1] != a_i[W-1]);
`ifdef STREAM_WINDOW_ACC_SATURATE_EN
        if (ovf_o) begin
            sum_o = a_i[W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            sum_o = rawSum;
        end
`else
        sum_o = rawSum;
`endif
    end

endmodule

// File: rtl/stream_window_acc.sv
// Windowed stream accumulator: after an accepted run it waits delay0 cycles,
// sums period samples of in0, then publishes the sum on out0 with a done pulse.
// Build option: STREAM_WINDOW_ACC_SATURATE_EN (clamp instead of wrap).
module stream_window_acc
    import stream_window_acc_pkg::*;
#(
    parameter int DATA_W = SWA_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [CNT_W-1:0]  delay0,
    input  logic [CNT_W-1:0]  period,
    input  logic [DATA_W-1:0] in0,
    output logic              running,
    output logic              done,
    output logic [DATA_W-1:0] out0,
    output logic              overflow
);

    swa_state_e        state_q;
    logic [CNT_W-1:0]  delayCnt_q;
    logic [CNT_W-1:0]  periodCnt_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] out0_q;
    logic              done_q;
    logic              running_q;
    logic              overflow_q;

    logic [DATA_W-1:0] acc_d;
    logic              addOvf;

    swa_add_ovf #(
        .W (DATA_W)
    ) u_add (
        .a_i   (acc_q),
        .b_i   (in0),
        .sum_o (acc_d),
        .ovf_o (addOvf)
    );

    // Control FSM with counters; outputs are registered so that done and the
    // new out0 appear in the FINISH cycle and running drops in that same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SWA_IDLE;
            delayCnt_q  <= '0;
            periodCnt_q <= '0;
            acc_q       <= '0;
            out0_q      <= '0;
            done_q      <= 1'b0;
            running_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                SWA_IDLE: begin
                    if (run) begin
                        acc_q       <= '0;
                        overflow_q  <= 1'b0;
                        delayCnt_q  <= delay0;
                        periodCnt_q <= period;
                        if (delay0 != '0) begin
                            state_q   <= SWA_DELAY;
                            running_q <= 1'b1;
                        end else if (period != '0) begin
                            state_q   <= SWA_ACC;
                            running_q <= 1'b1;
                        end else begin
                            state_q <= SWA_FINISH;
                            out0_q  <= '0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SWA_DELAY: begin
                    delayCnt_q <= delayCnt_q - CNT_W'(1);
                    if (delayCnt_q == CNT_W'(1)) begin
                        if (periodCnt_q != '0) begin
                            state_q <= SWA_ACC;
                        end else begin
                            state_q   <= SWA_FINISH;
                            running_q <= 1'b0;
                            out0_q    <= '0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                SWA_ACC: begin
                    acc_q       <= acc_d;
                    periodCnt_q <= periodCnt_q - CNT_W'(1);
                    if (addOvf) begin
                        overflow_q <= 1'b1;
                    end
                    if (periodCnt_q == CNT_W'(1)) begin
                        state_q   <= SWA_FINISH;
                        running_q <= 1'b0;
                        out0_q    <= acc_d;
                        done_q    <= 1'b1;
                    end
                end
                SWA_FINISH: begin
                    state_q <= SWA_IDLE;
                end
                default: begin
                    state_q <= SWA_IDLE;
                end
            endcase
        end
    end

    assign running  = running_q;
    assign done     = done_q;
    assign out0     = out0_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_stream_window_acc.sv
// Self-checking bench for stream_window_acc. Expected results are pushed to a
// scoreboard queue when a run is driven and popped when done is seen.
// Honours STREAM_WINDOW_ACC_SATURATE_EN for the expected overflow result.
module tb_stream_window_acc;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] delay0;
    logic [15:0] period;
    logic [31:0] in0;
    logic        running;
    logic        done;
    logic [31:0] out0;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] sum;
        logic        ovf;
    } expect_t;

    expect_t sbQueue[$];

    stream_window_acc #(
        .DATA_W (32),
        .CNT_W  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .delay0   (delay0),
        .period   (period),
        .in0      (in0),
        .running  (running),
        .done     (done),
        .out0     (out0),
        .overflow (overflow)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference signed add: wrap, or clamp when the saturating build is selected.
    function automatic logic [32:0] modelAdd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        logic        v;
        s = a + b;
        v = (a[31] == b[31]) && (s[31] != a[31]);
`ifdef STREAM_WINDOW_ACC_SATURATE_EN
        if (v) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {v, s};
    endfunction

    // Drives one run: samples are base, base+step, ... during the window and
    // 100 elsewhere. Optionally re-pulses run in DELAY and FINISH while also
    // changing delay0/period, which must all be ignored.
    task automatic applyStimulus(input int d, input int p, input logic [31:0] base,
                                 input logic [31:0] step, input bit disturb);
        logic [31:0] acc;
        logic        ovf;
        logic [32:0] r;
        logic [31:0] sample;
        acc = '0;
        ovf = 1'b0;
        sample = base;
        for (int i = 0; i < p; i++) begin
            r = modelAdd(acc, sample);
            acc = r[31:0];
            ovf = ovf | r[32];
            sample = sample + step;
        end
        sbQueue.push_back('{sum: acc, ovf: ovf});

        @(posedge clk); #1;
        run    = 1'b1;
        delay0 = 16'(d);
        period = 16'(p);
        in0    = 32'd100;
        sample = base;
        for (int k = 1; k <= d + p + 1; k++) begin
            @(posedge clk); #1;
            run = 1'b0;
            if (disturb && k == 1) begin
                run    = 1'b1;
                delay0 = 16'd0;
                period = 16'd7;
            end
            if (disturb && k == d + p + 1) begin
                run = 1'b1;
            end
            if (k >= d + 1 && k <= d + p) begin
                in0    = sample;
                sample = sample + step;
            end else begin
                in0 = 32'd100;
            end
            @(negedge clk);
            checkOutput($sformatf("running_k%0d", k), 64'(running), 64'(k <= d + p));
            checkOutput($sformatf("done_k%0d", k), 64'(done), 64'(k == d + p + 1));
        end
    endtask

    // Scoreboard consumer: every done must match the oldest pending result.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpectedDone", 64'(done), 64'd0);
            end else begin
                expect_t e;
                e = sbQueue.pop_front();
                checkOutput("out0", 64'(out0), 64'(e.sum));
                checkOutput("overflow", 64'(overflow), 64'(e.ovf));
            end
        end
    end

    initial begin
        rst    = 1'b0;
        run    = 1'b0;
        delay0 = '0;
        period = '0;
        in0    = '0;

        @(negedge clk);
        checkOutput("rstOut0", 64'(out0), 64'd0);
        checkOutput("rstRunning", 64'(running), 64'd0);
        checkOutput("rstDone", 64'(done), 64'd0);
        checkOutput("rstOverflow", 64'(overflow), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        $display("[TB] basic window with delay");
        applyStimulus(2, 4, 32'd1, 32'd1, 1'b0);
        $display("[TB] zero delay and zero period");
        applyStimulus(0, 0, 32'd0, 32'd0, 1'b0);
        applyStimulus(0, 3, -32'sd5, 32'd0, 1'b0);
        $display("[TB] signed overflow");
        applyStimulus(1, 2, 32'h7FFF_FFFF, 32'd0, 1'b0);
        applyStimulus(0, 2, 32'd5, 32'd1, 1'b0);
        $display("[TB] run re-pulsed mid-run");
        applyStimulus(3, 2, 32'd10, 32'd1, 1'b1);

        $display("[TB] reset during accumulation");
        @(posedge clk); #1;
        run    = 1'b1;
        delay0 = 16'd0;
        period = 16'd4;
        @(posedge clk); #1;
        run = 1'b0;
        in0 = 32'd3;
        @(posedge clk); #1;
        in0 = 32'd4;
        @(posedge clk); #1;
        rst = 1'b0;
        in0 = 32'd5;
        @(negedge clk);
        checkOutput("midRstOut0", 64'(out0), 64'd0);
        checkOutput("midRstRunning", 64'(running), 64'd0);
        checkOutput("midRstDone", 64'(done), 64'd0);
        checkOutput("midRstOverflow", 64'(overflow), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("postRstNoDone", 64'(done), 64'd0);
            checkOutput("postRstIdle", 64'(running), 64'd0);
        end

        applyStimulus(1, 1, 32'd9, 32'd0, 1'b0);

        repeat (3) @(posedge clk);
        checkOutput("sbEmpty", 64'(sbQueue.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_window_acc.md
# stream_window_acc

Windowed stream accumulator for the Versat datapath, placed directly downstream of a fixed-latency buffer stage. After a `run` pulse it waits a configured number of cycles so that delayed data lines up, sums `in0` over a configured window of cycles, then presents the sum on `out0` with a one-cycle `done` pulse. It turns a buffered stream into one scalar result per run, such as a dot-product tail or a reduction.

## Interface
Parameters:
- `DATA_W`, 32, width of the input sample and of the result.
- `CNT_W`, 16, width of the delay and window counters.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset; asynchronous, active-low.
- `run`  input  1  start pulse; sampled only in IDLE.
- `delay0`  input  CNT_W  cycles to wait before the first sample; latched on accepted `run`.
- `period`  input  CNT_W  number of samples to accumulate; latched on accepted `run`.
- `in0`  input  DATA_W  signed two's-complement sample.
- `running`  output  1  high while a run is in progress.
- `done`  output  1  one-cycle pulse when `out0` is updated.
- `out0`  output  DATA_W  registered result; holds its value between runs.
- `overflow`  output  1  sticky flag: signed overflow occurred in the last window.

## Operation
- States:
  - IDLE: `running`=0.
  - DELAY: counts down the latched `delay0`.
  - ACC: adds `in0` each cycle and counts down the latched `period`.
  - FINISH: single cycle; writes `out0`, pulses `done`.
- IDLE→DELAY when `run`=1 and `delay0`≠0.
- IDLE→ACC when `run`=1, `delay0`=0 and `period`≠0.
- IDLE→FINISH when `run`=1, `delay0`=0 and `period`=0.
- DELAY→ACC when the delay count expires and `period`≠0; DELAY→FINISH when it expires and `period`=0.
- ACC→FINISH after `period` samples. FINISH→IDLE unconditionally.
- On an accepted `run`:
  - the internal accumulator clears to 0;
  - `overflow` clears to 0;
  - `delay0` and `period` are latched. Later changes on those inputs are ignored until the next run.
- `run` asserted outside IDLE is ignored. This includes `run` asserted in the FINISH cycle.
- Arithmetic: signed DATA_W addition. Default behaviour wraps modulo 2^DATA_W. On signed overflow (operands same sign, result sign differs) `overflow` is set and stays set until the next accepted `run`.
- `period`=0 gives `out0`=0 and `done` still pulses.
- Reset (any time, including mid-run):
  - state→IDLE;
  - `out0`=0, `done`=0, `running`=0, `overflow`=0;
  - accumulator and counters cleared.

## Timing
- Let T be the cycle in which an accepted `run` is high.
- `running`=1 in cycles T+1 through T+delay0+period. It is 0 in the `done` cycle.
- `in0` is summed in cycles T+delay0+1 through T+delay0+period inclusive, exactly `period` samples.
- `done`=1 and the new `out0` are visible in cycle T+delay0+period+1. `out0` holds thereafter.
- The earliest next accepted `run` is in cycle T+delay0+period+2.
- `delay0`=0, `period`=0: `done` in T+1, `running` never asserted.
- A fixed buffer of AMOUNT stages in front of this block adds AMOUNT+1 cycles. Software compensates by programming `delay0`.

## Configuration
- `STREAM_WINDOW_ACC_SATURATE_EN` defined: on signed overflow the accumulator clamps to the signed maximum (positive overflow) or minimum (negative overflow). Accumulation continues from the clamped value. `overflow` is still set.
- Macro undefined: wrap-around arithmetic as in Operation. `overflow` behaviour is identical.

## Structure
- Shared package holds:
  - state encoding typedef (IDLE, DELAY, ACC, FINISH);
  - `SWA_SMAX`/`SWA_SMIN` constants derived from DATA_W.
- One sub-module, `swa_add_ovf`: combinational signed adder. It outputs the sum and an overflow bit, and applies saturation when the macro is defined.
- The state machine, counters and output registers live in `stream_window_acc`.

## Test plan
- Reset mid-ACC (`rst` low for 1 cycle during a window with partial sum 7) → `out0`=0, `running`=0, `done`=0, `overflow`=0 immediately. No `done` follows.
- `delay0`=2, `period`=4, `in0` = 1,2,3,4 in cycles T+3..T+6 (other cycles 100) → `done` at T+7, `out0`=10, `running` high T+1..T+6.
- `delay0`=0, `period`=0 → `done` at T+1, `out0`=0. A second run with `period`=3 and `in0`=-5 constant → `out0`=-15.
- `run` re-pulsed during DELAY and during FINISH → ignored. Exactly one `done`; `delay0`/`period` changed mid-run have no effect.
- DATA_W=32, `period`=2, `in0`=0x7FFFFFFF twice:
  - without the macro → `out0`=0xFFFFFFFE, `overflow`=1;
  - with `STREAM_WINDOW_ACC_SATURATE_EN` → `out0`=0x7FFFFFFF, `overflow`=1.
- Back-to-back runs (`run` at T+delay0+period+2) → the second sum is independent of the first and `overflow` is cleared.
